// File: rtl/iic_read_seq_if.sv
// ---------------------------------------------------------------------------
// iic_read_seq_if
// Bundle of every non-clock signal of the burst read sequencer.
//   master : the sequencer itself (drives O_*, samples I_*)
//   slave  : the surroundings: start/consumer logic and the byte read engine
//   Start request : I_start, I_base_addr[7:0], I_count[3:0]
//   Engine side   : O_recv_en, O_dev_addr[6:0], O_word_addr[7:0],
//                   I_read_data[7:0], I_done_flag
//   Byte stream   : O_data[7:0], O_data_valid, I_data_ready
//   Status        : O_busy, O_done, O_err, O_err_addr[7:0]
// ---------------------------------------------------------------------------
interface iic_read_seq_if;
    logic       I_start;
    logic [7:0] I_base_addr;
    logic [3:0] I_count;
    logic       O_recv_en;
    logic [6:0] O_dev_addr;
    logic [7:0] O_word_addr;
    logic [7:0] I_read_data;
    logic       I_done_flag;
    logic [7:0] O_data;
    logic       O_data_valid;
    logic       I_data_ready;
    logic       O_busy;
    logic       O_done;
    logic       O_err;
    logic [7:0] O_err_addr;

    modport master (
        input  I_start, I_base_addr, I_count, I_read_data, I_done_flag, I_data_ready,
        output O_recv_en, O_dev_addr, O_word_addr, O_data, O_data_valid,
               O_busy, O_done, O_err, O_err_addr
    );

    modport slave (
        output I_start, I_base_addr, I_count, I_read_data, I_done_flag, I_data_ready,
        input  O_recv_en, O_dev_addr, O_word_addr, O_data, O_data_valid,
               O_busy, O_done, O_err, O_err_addr
    );
endinterface

// File: rtl/iic_read_seq.sv
// ---------------------------------------------------------------------------
// iic_read_seq
// Burst read sequencer placed in front of a single-byte I2C read engine.
// One start pulse reads I_count consecutive word addresses: the engine enable
// is pulsed once per byte, the returned byte is offered on a valid/ready
// stream, each engine transaction is bounded by a timeout and retried, and a
// byte that keeps timing out aborts the burst with its address reported.
// Ports:
//   I_clk   : clock
//   I_rst_n : asynchronous active-low reset
//   bus     : iic_read_seq_if.master (start request, engine, stream, status)
// ---------------------------------------------------------------------------
module iic_read_seq #(
    parameter logic [6:0]  C_DEV_ADDR  = 7'h50,
    parameter logic [19:0] C_TIMEOUT   = 20'd600000,
    parameter logic [1:0]  C_MAX_RETRY = 2'd2,
    parameter logic [2:0]  C_GAP       = 3'd4
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    iic_read_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_PUSH, S_GAP, S_FINISH
    } state_t;

    state_t      r_state, w_next;

    logic        r_recv_en;
    logic [7:0]  r_word_addr;
    logic [7:0]  r_data;
    logic        r_data_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_err_addr;
    logic [3:0]  r_remain;
    logic [1:0]  r_retry;
    logic [19:0] r_tcnt;
    logic [2:0]  r_gcnt;

    // decoded events of the current cycle
    logic w_start, w_got, w_tmo, w_retry, w_abort, w_accept, w_gap_end;

    // ---------------- state register ----------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = (bus.I_count == 4'd0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_got)        w_next = S_PUSH;
                else if (w_retry) w_next = S_GAP;
                else if (w_abort) w_next = S_FINISH;
            end
            S_PUSH:   if (w_accept) w_next = (r_remain == 4'd1) ? S_FINISH : S_GAP;
            S_GAP:    if (w_gap_end) w_next = S_ISSUE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- output / event decode ----------------
    always_comb begin
        w_start   = (r_state == S_IDLE) && bus.I_start;
        w_got     = (r_state == S_WAIT) && bus.I_done_flag;
        // a done arriving on the last counted clock still wins over the timeout
        w_tmo     = (r_state == S_WAIT) && !bus.I_done_flag && (r_tcnt == C_TIMEOUT - 20'd1);
        w_retry   = w_tmo && (r_retry < C_MAX_RETRY);
        w_abort   = w_tmo && !(r_retry < C_MAX_RETRY);
        w_accept  = (r_state == S_PUSH) && r_data_valid && bus.I_data_ready;
        w_gap_end = (r_state == S_GAP) && (r_gcnt == C_GAP - 3'd1);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_recv_en    <= 1'b0;
            r_word_addr  <= 8'h00;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_addr   <= 8'h00;
            r_remain     <= 4'd0;
            r_retry      <= 2'd0;
            r_tcnt       <= 20'd0;
            r_gcnt       <= 3'd0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (r_state == S_FINISH) r_busy <= 1'b0;

            if (w_start) begin
                r_word_addr <= bus.I_base_addr;
                r_remain    <= bus.I_count;
                r_retry     <= 2'd0;
                r_err       <= 1'b0;
                r_err_addr  <= 8'h00;
                r_busy      <= 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_recv_en <= 1'b1;
                r_tcnt    <= 20'd0;
            end

            if (r_state == S_WAIT) r_tcnt <= r_tcnt + 20'd1;

            // enable must drop on the done edge, or the engine starts again
            if (w_got) begin
                r_data       <= bus.I_read_data;
                r_data_valid <= 1'b1;
                r_recv_en    <= 1'b0;
                r_retry      <= 2'd0;
            end

            if (w_tmo)   r_recv_en <= 1'b0;
            if (w_retry) r_retry   <= r_retry + 2'd1;
            if (w_abort) begin
                r_err      <= 1'b1;
                r_err_addr <= r_word_addr;
            end

            if (w_accept) begin
                r_data_valid <= 1'b0;
                r_remain     <= r_remain - 4'd1;
                r_word_addr  <= r_word_addr + 8'd1;
            end

            // gap counter runs only while idling the engine between attempts
            if (r_state == S_GAP) r_gcnt <= r_gcnt + 3'd1;
            else                  r_gcnt <= 3'd0;
        end
    end

    assign bus.O_recv_en    = r_recv_en;
    assign bus.O_dev_addr   = C_DEV_ADDR;
    assign bus.O_word_addr  = r_word_addr;
    assign bus.O_data       = r_data;
    assign bus.O_data_valid = r_data_valid;
    assign bus.O_busy       = r_busy;
    assign bus.O_done       = r_done;
    assign bus.O_err        = r_err;
    assign bus.O_err_addr   = r_err_addr;

endmodule

// File: tb/tb_iic_read_seq.sv
// ---------------------------------------------------------------------------
// tb_iic_read_seq
// Scoreboard bench for iic_read_seq. A burst-level reference model decides,
// per byte, which engine attempts answer and thereby which bytes, errors and
// done pulses the sequencer must produce. An engine model answers enables
// from the planned attempt list; a monitor pops expectations on every stream
// handshake and done pulse.
// ---------------------------------------------------------------------------
module tb_iic_read_seq;

    localparam int TMO    = 100;
    localparam int MAXR   = 2;
    localparam int GAP    = 4;
    localparam int NORESP = 100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iic_read_seq_if bus();

    iic_read_seq #(
        .C_DEV_ADDR (7'h50),
        .C_TIMEOUT  (20'd100),
        .C_MAX_RETRY(2'd2),
        .C_GAP      (3'd4)
    ) dut (
        .I_clk  (clk),
        .I_rst_n(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] addr;
        int         lat;
        logic [7:0] data;
    } att_t;

    typedef struct {
        bit         is_done;
        logic [7:0] data;
        bit         err;
        logic [7:0] eaddr;
    } exp_t;

    att_t eng_q[$];
    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;

    logic [7:0] g_dead     = 8'h20;
    int         g_dead_n   = 0;
    bit         g_edge     = 1'b0;
    bit         g_rand_to  = 1'b0;
    int         g_rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Engine answer latency of one attempt (cycles after enable rise);
    // NORESP means the engine never answers.
    function automatic int gen_lat(input logic [7:0] a, input int att);
        if (a == g_dead && att < g_dead_n) return NORESP;
        if (g_edge) return TMO - 1;
        if (g_rand_to) begin
            if ($urandom_range(0, 4) == 0) return NORESP;
            if ($urandom_range(0, 9) == 0) return TMO - 1;
        end
        return int'($urandom_range(0, 30));
    endfunction

    // Reference model: per byte up to 1+MAXR attempts; the first one that
    // answers within TMO delivers the byte, otherwise the burst aborts there.
    task automatic model_burst(input logic [7:0] base, input int cnt);
        logic [7:0] a;
        bit ok;
        att_t t;
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            a  = base + 8'(i);
            ok = 1'b0;
            for (int k = 0; k <= MAXR; k++) begin
                t.addr = a;
                t.lat  = gen_lat(a, k);
                t.data = 8'($urandom);
                eng_q.push_back(t);
                if (t.lat < TMO) begin
                    ok = 1'b1;
                    e = '{is_done: 1'b0, data: t.data, err: 1'b0, eaddr: 8'h00};
                    exp_q.push_back(e);
                    break;
                end
            end
            if (!ok) begin
                e = '{is_done: 1'b1, data: 8'h00, err: 1'b1, eaddr: a};
                exp_q.push_back(e);
                return;
            end
        end
        e = '{is_done: 1'b1, data: 8'h00, err: 1'b0, eaddr: 8'h00};
        exp_q.push_back(e);
    endtask

    // Called at a negedge. Checks start latency on the way.
    task automatic issue_burst(input logic [7:0] base, input int cnt);
        model_burst(base, cnt);
        bus.I_base_addr = base;
        bus.I_count     = cnt[3:0];
        bus.I_start     = 1'b1;
        @(negedge clk);
        bus.I_start = 1'b0;
        chk("start_busy", bus.O_busy, 1);
        chk("start_no_done", bus.O_done, 0);
        @(negedge clk);
        if (cnt > 0) chk("start_enable", bus.O_recv_en, 1);
        else begin
            chk("cnt0_done", bus.O_done, 1);
            chk("cnt0_busy", bus.O_busy, 0);
            chk("cnt0_no_enable", bus.O_recv_en, 0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || bus.O_busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("burst_completes", n < 20000, 1);
        chk("attempts_consumed", eng_q.size(), 0);
        if (n >= 20000) begin
            exp_q.delete();
            eng_q.delete();
        end
        @(negedge clk);
    endtask

    // Engine model: answers planned attempts, checks address stability,
    // window lengths and enable-low gaps.
    initial begin
        att_t cur;
        bit prev_en = 1'b0, active = 1'b0, had_win = 1'b0;
        int win = 0, low_cnt = 0;
        cur = '{addr: 8'h00, lat: 0, data: 8'h00};
        bus.I_done_flag = 1'b0;
        bus.I_read_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.I_done_flag = 1'b0;
            if (!rst_n) begin
                prev_en = 1'b0; active = 1'b0; had_win = 1'b0; low_cnt = 0;
            end else begin
                if (!bus.O_busy) had_win = 1'b0;
                if (bus.O_recv_en && !prev_en) begin
                    if (had_win) chk("enable_gap_ge_cgap", low_cnt >= GAP, 1);
                    chk("enable_expected", eng_q.size() > 0, 1);
                    if (eng_q.size() > 0) begin
                        cur = eng_q.pop_front();
                        active = 1'b1;
                        win = 0;
                    end
                end
                if (bus.O_recv_en) begin
                    if (active) begin
                        chk("word_addr_in_window", bus.O_word_addr, cur.addr);
                        chk("dev_addr", bus.O_dev_addr, 7'h50);
                        win++;
                        if (cur.lat < TMO && win == cur.lat + 1) begin
                            bus.I_done_flag = 1'b1;
                            bus.I_read_data = cur.data;
                        end
                    end
                end else if (prev_en) begin
                    if (active) begin
                        if (cur.lat < TMO) begin
                            chk("enable_drop_on_done", win, cur.lat + 1);
                            chk("valid_on_done", bus.O_data_valid, 1);
                        end else begin
                            chk("timeout_window_len", win, TMO);
                        end
                    end
                    active  = 1'b0;
                    had_win = 1'b1;
                    low_cnt = 1;
                end else begin
                    low_cnt++;
                end
                prev_en = bus.O_recv_en;
            end
        end
    end

    // Consumer ready: 0 = always, 1 = random, 2 = low for 50 clocks after valid
    initial begin
        int bp = 0;
        bus.I_data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (g_rdy_mode == 2) begin
                if (bus.O_data_valid) bp++;
                bus.I_data_ready = (bp > 50);
            end else begin
                bp = 0;
                if (g_rdy_mode == 1) bus.I_data_ready = 1'($urandom_range(0, 1));
                else                 bus.I_data_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit pv = 1'b0, phs = 1'b0;
        logic [7:0] pdata = 8'h00;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0; phs = 1'b0;
            end else begin
                if (bus.O_data_valid) chk("no_enable_while_valid", bus.O_recv_en, 0);
                if (pv && !phs) begin
                    chk("valid_held", bus.O_data_valid, 1);
                    chk("data_held", bus.O_data, pdata);
                end
                if (bus.O_data_valid && bus.I_data_ready) begin
                    chk("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("byte_not_done", e.is_done, 0);
                        chk("stream_data", bus.O_data, e.data);
                    end
                end
                if (bus.O_done) begin
                    chk("done_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("done_not_byte", e.is_done, 1);
                        chk("done_err", bus.O_err, e.err);
                        chk("done_err_addr", bus.O_err_addr, e.eaddr);
                        chk("busy_low_at_done", bus.O_busy, 0);
                    end
                end
                pv    = bus.O_data_valid;
                phs   = bus.O_data_valid && bus.I_data_ready;
                pdata = bus.O_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.I_start     = 1'b0;
        bus.I_base_addr = 8'h00;
        bus.I_count     = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_recv_en", bus.O_recv_en, 0);
        chk("rst_word_addr", bus.O_word_addr, 0);
        chk("rst_dev_addr", bus.O_dev_addr, 7'h50);
        chk("rst_data", bus.O_data, 0);
        chk("rst_valid", bus.O_data_valid, 0);
        chk("rst_busy", bus.O_busy, 0);
        chk("rst_done", bus.O_done, 0);
        chk("rst_err", bus.O_err, 0);
        chk("rst_err_addr", bus.O_err_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // normal burst, ready high
        issue_burst(8'h10, 3); wait_done();
        // backpressure after the first valid
        g_rdy_mode = 2; issue_burst(8'h30, 3); wait_done(); g_rdy_mode = 0;
        // address wrap
        issue_burst(8'hFE, 3); wait_done();
        // dead address: three full windows then abort
        g_dead = 8'h20; g_dead_n = 3;
        issue_burst(8'h20, 2); wait_done();
        repeat (3) @(negedge clk);
        chk("err_held", bus.O_err, 1);
        chk("err_addr_held", bus.O_err_addr, 8'h20);
        // answers on the second attempt
        g_dead_n = 1; issue_burst(8'h20, 1); wait_done();
        g_dead_n = 0;
        // empty burst
        issue_burst(8'h00, 0); wait_done();
        // start while busy is ignored
        issue_burst(8'h50, 3);
        repeat (4) @(negedge clk);
        if (bus.O_busy) begin
            bus.I_base_addr = 8'hAA;
            bus.I_count     = 4'd7;
            bus.I_start     = 1'b1;
            @(negedge clk);
            bus.I_start = 1'b0;
        end
        wait_done();
        // done exactly on the timeout edge
        g_edge = 1'b1; issue_burst(8'h40, 2); wait_done(); g_edge = 1'b0;
        // async reset while waiting on the engine
        g_dead = 8'h60; g_dead_n = 3;
        issue_burst(8'h60, 2);
        repeat (10) @(negedge clk);
        chk("pre_reset_enable", bus.O_recv_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_recv_en", bus.O_recv_en, 0);
        chk("async_rst_busy", bus.O_busy, 0);
        chk("async_rst_done", bus.O_done, 0);
        chk("async_rst_word_addr", bus.O_word_addr, 0);
        repeat (2) @(negedge clk);
        eng_q.delete();
        exp_q.delete();
        g_dead_n = 0;
        rst_n = 1'b1;
        @(negedge clk);
        issue_burst(8'h61, 2); wait_done();

        // randomized bursts
        g_rand_to = 1'b1; g_rdy_mode = 1;
        for (int i = 0; i < 25; i++) begin
            g_dead   = 8'($urandom);
            g_dead_n = int'($urandom_range(0, 3));
            issue_burst(8'($urandom), int'($urandom_range(0, 15)));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
